video_wb_arbiter: RTL
=====================

# video_wb_arbiter

Two-master Wishbone arbiter and bus controller for the video subsystem. It shares the single external Wishbone master port between the video-in store engine (master 0, writes captured pixels to RAM) and the video-out fetch engine (master 1, reads frames from RAM). It grants whole bus cycles, giving priority to an urgent video-out request and round-robin otherwise. An ACK watchdog aborts transfers to a dead slave so that neither engine hangs.

## Interface
- TIMEOUT, 64: cycles with STB asserted and no ACK/ERR before the arbiter aborts the transfer (≥2).
- clk  in  1  single clock; all logic on posedge.
- nRST  in  1  reset, synchronous, active-low.
- m0_wb_CYC_I, m0_wb_STB_I, m0_wb_WE_I  in  1 each  master 0 cycle/strobe/write.
- m0_wb_SEL_I  in  4  master 0 byte select.
- m0_wb_ADR_I, m0_wb_DAT_I  in  32 each  master 0 address/write data.
- m0_wb_ACK_O, m0_wb_ERR_O  out  1 each  master 0 acknowledge/error.
- m0_wb_DAT_O  out  32  master 0 read data.
- m1_*  (same set as m0_*)  master 1 (video-out fetch).
- m1_urgent  in  1  video-out FIFO below low-water mark; raises master 1 priority.
- p_wb_CYC_O, p_wb_STB_O, p_wb_WE_O  out  1 each  shared bus to slave.
- p_wb_SEL_O  out  4; p_wb_ADR_O, p_wb_DAT_O  out  32 each.
- p_wb_DAT_I  in  32; p_wb_ACK_I, p_wb_ERR_I  in  1 each.
- grant  out  2  one-hot current owner (01 = m0, 10 = m1, 00 = none).
- bus_timeout  out  1  one-cycle pulse on watchdog abort.

## Operation
- FSM states: IDLE, GRANT0, GRANT1, ABORT. Registered state; reset → IDLE.
- IDLE arbitration, evaluated on the sampled CYC inputs:
  - m1_CYC && m1_urgent → GRANT1.
  - Only one CYC high → that master's grant.
  - Both high, not urgent → the master not in last_grant. last_grant resets to 1, so m0 wins the first contention.
  - Neither high → stay IDLE.
- GRANTx: the granted master's CYC/STB/WE/SEL/ADR/DAT are forwarded combinationally to p_wb_*. p_wb_ACK_I/ERR_I/DAT_I are forwarded to the granted master only.
  - The non-granted master sees ACK_O = ERR_O = 0 and DAT_O = 0.
  - Multiple transfers (STB pulses) under one CYC stay granted; no preemption mid-cycle.
- Release: the granted master drops CYC → p_wb_CYC_O drops in the same cycle. Next state is IDLE and last_grant is set to x.
- Watchdog: a 16-bit counter increments each GRANTx cycle with forwarded STB=1 and ACK_I=ERR_I=0. It clears on ACK, ERR, STB=0, or state change. Reaching TIMEOUT → ABORT.
- ABORT (exactly 1 cycle):
  - p_wb_CYC_O = STB_O = 0.
  - ERR_O = 1 to the aborted master; bus_timeout = 1.
  - last_grant = aborted master; next state IDLE.
- In IDLE and ABORT all p_wb_* outputs are 0.
- grant reflects state: GRANT0 → 01, GRANT1 → 10, else 00.

## Timing
- Reset (nRST low at a posedge): state IDLE, last_grant = 1, counter 0. All outputs 0: p_wb_*, m*_ACK_O, m*_ERR_O, m*_DAT_O, grant, bus_timeout.
- A reset mid-transfer drops p_wb_CYC_O at that edge; no ERR is issued.
- Grant latency: CYC rises in cycle N with the bus IDLE → GRANTx from edge N+1; p_wb_CYC_O is high in cycle N+1.
- Minimum one IDLE cycle between consecutive grants, including the same master re-requesting.
- ACK_I/ERR_I → master ACK_O/ERR_O: 0 cycles (combinational).
- Simultaneous ACK_I and counter reaching TIMEOUT: ACK wins, no abort.
- Simultaneous CYC drop and TIMEOUT: release wins, no abort.
- m1_urgent is sampled only in IDLE. Asserting it during GRANT0 does not preempt m0.
- Counter saturates logic: TIMEOUT compare is equality; the counter never wraps while in GRANTx.

## Test plan
- Reset: hold nRST=0 3 cycles with both CYC=1 → all outputs 0, grant=00. Release → grant=01 one cycle later (m0 wins first contention).
- Round-robin: both masters hold CYC, each drops CYC after 4 ACKed transfers → grant sequence 01, 00, 10, 00, 01, with exactly one IDLE cycle between owners.
- Urgent: m0 and m1 request in the same cycle from IDLE with m1_urgent=1 → grant=10. Raising m1_urgent during GRANT0 does not change grant until m0 drops CYC.
- Isolation: during GRANT0, slave ACKs m0 writes to 0x1000..0x100C → m1_wb_ACK_O stays 0. p_wb_ADR_O follows m0_wb_ADR_I, and p_wb_WE_O=1.
- Watchdog (TIMEOUT=64): slave never ACKs → after 64 stalled cycles, one cycle with m0_wb_ERR_O=1, bus_timeout=1, p_wb_CYC_O=0. Then IDLE, and a pending m1 is granted next.
- Race: ACK_I arrives on the exact cycle the counter hits 64 → m0_wb_ACK_O=1, no ERR, bus_timeout stays 0.

Source files
------------

// File: rtl/video_wb_arbiter_if.sv
// Wishbone bus bundle shared by the video engines, the arbiter and the RAM slave.
interface video_wb_arbiter_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        ack;
    logic        err;

    modport master (output cyc, stb, we, sel, adr, dat_w, input dat_r, ack, err);
    modport slave  (input cyc, stb, we, sel, adr, dat_w, output dat_r, ack, err);
endinterface

// File: rtl/video_wb_arbiter.sv
// Two-master Wishbone arbiter for video-in store (m0) and video-out fetch (m1),
// with urgent priority for m1, round-robin otherwise, and an ACK watchdog.
module video_wb_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  nRST,
    video_wb_arbiter_if.slave     m0,
    video_wb_arbiter_if.slave     m1,
    video_wb_arbiter_if.master    p,
    input  logic                  m1_urgent,
    output logic [1:0]            grant,
    output logic                  bus_timeout
);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, ABORT} state_t;

    state_t      state, state_nxt;
    logic        last_grant, last_grant_nxt;
    logic [15:0] wd_cnt, wd_cnt_nxt;
    logic        own_cyc, own_stb, stall;

    always_ff @(posedge clk) begin
        if (!nRST) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            wd_cnt     <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            wd_cnt     <= wd_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        wd_cnt_nxt     = '0;
        own_cyc        = 1'b0;
        own_stb        = 1'b0;
        stall          = 1'b0;
        grant          = 2'b00;
        bus_timeout    = 1'b0;
        p.cyc          = 1'b0;
        p.stb          = 1'b0;
        p.we           = 1'b0;
        p.sel          = '0;
        p.adr          = '0;
        p.dat_w        = '0;
        m0.ack         = 1'b0;
        m0.err         = 1'b0;
        m0.dat_r       = '0;
        m1.ack         = 1'b0;
        m1.err         = 1'b0;
        m1.dat_r       = '0;

        case (state)
            IDLE: begin
                if (m1.cyc && m1_urgent)     state_nxt = GRANT1;
                else if (m0.cyc && m1.cyc)   state_nxt = last_grant ? GRANT0 : GRANT1;
                else if (m0.cyc)             state_nxt = GRANT0;
                else if (m1.cyc)             state_nxt = GRANT1;
            end
            GRANT0: begin
                grant    = 2'b01;
                own_cyc  = m0.cyc;
                own_stb  = m0.stb;
                p.cyc    = m0.cyc;
                p.stb    = m0.stb;
                p.we     = m0.we;
                p.sel    = m0.sel;
                p.adr    = m0.adr;
                p.dat_w  = m0.dat_w;
                m0.ack   = p.ack;
                m0.err   = p.err;
                m0.dat_r = p.dat_r;
            end
            GRANT1: begin
                grant    = 2'b10;
                own_cyc  = m1.cyc;
                own_stb  = m1.stb;
                p.cyc    = m1.cyc;
                p.stb    = m1.stb;
                p.we     = m1.we;
                p.sel    = m1.sel;
                p.adr    = m1.adr;
                p.dat_w  = m1.dat_w;
                m1.ack   = p.ack;
                m1.err   = p.err;
                m1.dat_r = p.dat_r;
            end
            ABORT: begin
                // last_grant already names the aborted master
                bus_timeout = 1'b1;
                if (last_grant) m1.err = 1'b1;
                else            m0.err = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Release beats the watchdog; an ACK/ERR in the final cycle clears the stall.
        if (state == GRANT0 || state == GRANT1) begin
            stall = own_cyc && own_stb && !p.ack && !p.err;
            if (!own_cyc) begin
                state_nxt      = IDLE;
                last_grant_nxt = (state == GRANT1);
            end else if (stall && wd_cnt == 16'(TIMEOUT - 1)) begin
                state_nxt      = ABORT;
                last_grant_nxt = (state == GRANT1);
            end else if (stall) begin
                wd_cnt_nxt = wd_cnt + 16'd1;
            end
        end
    end

endmodule
